// File: rtl/m92_pkg.sv
// Shared types for the M92 CPU-side memory responders.
package m92_pkg;

    localparam int unsigned ROM_TAG_W = 17;

    typedef logic [63:0] rom_line_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } rom_resp_state_t;

    // Word 0 lives in bits [15:0] of an SDRAM line.
    function automatic logic [15:0] rom_word(input rom_line_t line, input logic [1:0] sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/m92_rom_responder.sv
// CPU ROM responder: single 64-bit line buffer in front of the SDRAM CPU-ROM port,
// one mem_ready pulse per CPU access, wait states on a miss.
module m92_rom_responder
    import m92_pkg::*;
#(
    parameter int unsigned           SDR_AW   = 25,
    parameter logic [SDR_AW-1:0]     SDR_BASE = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              mem_req,
    input  logic              cpu_rom_memrq,
    input  logic [19:0]       rom_addr,
    input  logic              flush,
    output logic [15:0]       mem_dout,
    output logic              mem_ready,
    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic [63:0]       sdr_data
);

    rom_resp_state_t        state_q, state_d;
    rom_line_t              line_q, line_d;
    logic [ROM_TAG_W-1:0]   tag_q, tag_d;
    logic                   valid_q, valid_d;
    logic [ROM_TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic [1:0]             word_sel_q, word_sel_d;
    logic [15:0]            mem_dout_q, mem_dout_d;
    logic                   mem_ready_q, mem_ready_d;
    logic                   sdr_req_q, sdr_req_d;
    logic [SDR_AW-1:0]      sdr_addr_q, sdr_addr_d;

    logic                   start;
    logic                   hit;
    logic                   unused_byte_sel;

    // Byte lane is chosen by the CPU itself.
    assign unused_byte_sel = rom_addr[0];

    assign start = mem_req & cpu_rom_memrq;
    assign hit   = valid_q && (tag_q == rom_addr[19:3]);

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        pend_tag_d  = pend_tag_q;
        word_sel_d  = word_sel_q;
        mem_dout_d  = mem_dout_q;
        mem_ready_d = 1'b0;
        sdr_req_d   = sdr_req_q;
        sdr_addr_d  = sdr_addr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (hit) begin
                        mem_dout_d  = rom_word(line_q, rom_addr[2:1]);
                        mem_ready_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        pend_tag_d = rom_addr[19:3];
                        word_sel_d = rom_addr[2:1];
                        sdr_req_d  = 1'b1;
                        sdr_addr_d = SDR_BASE + SDR_AW'({rom_addr[19:3], 3'b000});
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (sdr_ack) begin
                    line_d      = sdr_data;
                    tag_d       = pend_tag_q;
                    valid_d     = 1'b1;
                    sdr_req_d   = 1'b0;
                    mem_dout_d  = rom_word(sdr_data, word_sel_q);
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!mem_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush racing a line fill still answers the CPU but leaves the buffer invalid.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            line_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            pend_tag_q  <= '0;
            word_sel_q  <= '0;
            mem_dout_q  <= '0;
            mem_ready_q <= 1'b0;
            sdr_req_q   <= 1'b0;
            sdr_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            pend_tag_q  <= pend_tag_d;
            word_sel_q  <= word_sel_d;
            mem_dout_q  <= mem_dout_d;
            mem_ready_q <= mem_ready_d;
            sdr_req_q   <= sdr_req_d;
            sdr_addr_q  <= sdr_addr_d;
        end
    end

    assign mem_dout  = mem_dout_q;
    assign mem_ready = mem_ready_q;
    assign sdr_req   = sdr_req_q;
    assign sdr_addr  = sdr_addr_q;

endmodule

// File: tb/tb_m92_rom_responder.sv
// Bench for m92_rom_responder: directed scenarios plus random accesses against a line-buffer model.
module tb_m92_rom_responder;

    localparam logic [24:0] BASE = 25'h0100000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic        cpu_rom_memrq;
    logic [19:0] rom_addr;
    logic        flush;
    logic [15:0] mem_dout;
    logic        mem_ready;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic        sdr_ack;
    logic [63:0] sdr_data;

    m92_rom_responder #(
        .SDR_AW   (25),
        .SDR_BASE (BASE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .mem_req       (mem_req),
        .cpu_rom_memrq (cpu_rom_memrq),
        .rom_addr      (rom_addr),
        .flush         (flush),
        .mem_dout      (mem_dout),
        .mem_ready     (mem_ready),
        .sdr_req       (sdr_req),
        .sdr_addr      (sdr_addr),
        .sdr_ack       (sdr_ack),
        .sdr_data      (sdr_data)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference model: what the buffer should hold.
    bit          m_valid = 1'b0;
    logic [16:0] m_tag   = '0;
    logic [63:0] m_line  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [15:0] pick(input logic [63:0] line, input logic [19:0] a);
        int unsigned idx;
        idx = a / 2 % 4;
        return 16'((line >> (idx * 16)) & 64'hFFFF);
    endfunction

    // One CPU access from IDLE through release of mem_req.
    task automatic access(input logic [19:0] a, input int dly, input logic [63:0] data,
                          input bit fl, input int hold);
        bit          hit;
        logic [24:0] exp_addr;
        mem_req       = 1'b1;
        cpu_rom_memrq = 1'b1;
        rom_addr      = a;
        hit = m_valid && (m_tag == a[19:3]);
        step();
        rom_addr = 20'($urandom);
        if (hit) begin
            check("hit_ready", 64'(mem_ready), 64'd1);
            check("hit_dout", 64'(mem_dout), 64'(pick(m_line, a)));
            check("hit_no_req", 64'(sdr_req), 64'd0);
        end else begin
            exp_addr = BASE + 25'(a & 20'hFFFF8);
            check("miss_ready", 64'(mem_ready), 64'd0);
            check("miss_req", 64'(sdr_req), 64'd1);
            check("miss_addr", 64'(sdr_addr), 64'(exp_addr));
            for (int i = 0; i < dly; i++) begin
                rom_addr = 20'($urandom);
                step();
                check("wait_req", 64'(sdr_req), 64'd1);
                check("wait_addr", 64'(sdr_addr), 64'(exp_addr));
                check("wait_ready", 64'(mem_ready), 64'd0);
            end
            sdr_ack  = 1'b1;
            sdr_data = data;
            flush    = fl;
            step();
            sdr_ack  = 1'b0;
            flush    = 1'b0;
            sdr_data = {$urandom, $urandom};
            check("fill_ready", 64'(mem_ready), 64'd1);
            check("fill_dout", 64'(mem_dout), 64'(pick(data, a)));
            check("fill_req_drop", 64'(sdr_req), 64'd0);
            m_line  = data;
            m_tag   = a[19:3];
            m_valid = !fl;
        end
        for (int i = 0; i < hold; i++) begin
            rom_addr = 20'($urandom);
            step();
            check("done_hold_ready", 64'(mem_ready), 64'd0);
            check("done_hold_req", 64'(sdr_req), 64'd0);
        end
        mem_req = 1'b0;
        step();
        check("release_ready", 64'(mem_ready), 64'd0);
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_valid = 1'b0;
        check("flush_ready", 64'(mem_ready), 64'd0);
    endtask

    logic [16:0] tags [4];

    initial begin
        tags[0] = 17'h00000;
        tags[1] = 17'h00001;
        tags[2] = 17'h14247;
        tags[3] = 17'h1FFFF;

        reset_n       = 1'b0;
        mem_req       = 1'b0;
        cpu_rom_memrq = 1'b0;
        rom_addr      = '0;
        flush         = 1'b0;
        sdr_ack       = 1'b0;
        sdr_data      = '0;
        #1;
        check("rst_dout", 64'(mem_dout), 64'd0);
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_req", 64'(sdr_req), 64'd0);
        check("rst_addr", 64'(sdr_addr), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Cold miss, then hit on the same line.
        access(20'h00006, 5, 64'h4444_3333_2222_1111, 1'b0, 0);
        access(20'h00002, 0, 64'h0, 1'b0, 0);
        // Miss to a new line replaces the old one.
        access(20'hA1238, 2, 64'h8888_7777_6666_5555, 1'b0, 0);
        access(20'h00000, 1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0, 0);
        // Flush racing ack: data returned, line not kept.
        access(20'h00010, 3, 64'h0123_4567_89AB_CDEF, 1'b1, 0);
        access(20'h00012, 0, 64'hFEDC_BA98_7654_3210, 1'b0, 0);

        // Non-ROM strobe is ignored.
        mem_req       = 1'b1;
        cpu_rom_memrq = 1'b0;
        rom_addr      = 20'h00012;
        for (int i = 0; i < 10; i++) begin
            step();
            check("nonrom_ready", 64'(mem_ready), 64'd0);
            check("nonrom_req", 64'(sdr_req), 64'd0);
        end
        mem_req = 1'b0;
        step();

        // Long hold in DONE gives one pulse, on hit and on miss.
        access(20'h00014, 0, 64'h0, 1'b0, 10);
        access(20'h55550, 4, 64'h1111_2222_3333_4444, 1'b0, 10);

        // Idle flush forces a refetch.
        idle_flush();
        access(20'h55552, 1, 64'h9999_AAAA_BBBB_CCCC, 1'b0, 0);

        // Reset mid-fetch.
        access(20'h00400, 1, 64'h0F0F_1E1E_2D2D_3C3C, 1'b0, 0);
        mem_req       = 1'b1;
        cpu_rom_memrq = 1'b1;
        rom_addr      = 20'h00800;
        step();
        check("prerst_req", 64'(sdr_req), 64'd1);
        step();
        reset_n = 1'b0;
        #1;
        check("rst_async_req", 64'(sdr_req), 64'd0);
        check("rst_async_addr", 64'(sdr_addr), 64'd0);
        mem_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        m_valid = 1'b0;
        step();
        sdr_ack  = 1'b1;
        sdr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        sdr_ack = 1'b0;
        check("stray_ack_ready", 64'(mem_ready), 64'd0);
        check("stray_ack_req", 64'(sdr_req), 64'd0);
        step();
        check("stray_ack_ready2", 64'(mem_ready), 64'd0);
        access(20'h00404, 2, 64'h5A5A_A5A5_0000_FFFF, 1'b0, 0);

        // Random accesses over a small set of lines.
        for (int n = 0; n < 60; n++) begin
            logic [19:0] a;
            a = {tags[$urandom_range(0, 3)], 3'($urandom)};
            if ($urandom_range(0, 7) == 0) begin
                idle_flush();
            end
            access(a, $urandom_range(0, 6), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m92_rom_responder.md
# m92_rom_responder

Memory-side responder for the main V33 CPU's ROM strobe: it services every access flagged `cpu_rom_memrq` by the address decoder. Each request is answered from a single 64-bit line buffer, or the line is fetched from SDRAM with a req/ack handshake. The block returns one 16-bit word and a one-cycle `mem_ready` pulse, and inserts wait states on a miss. It sits between the address decoder's `rom_addr`/`cpu_rom_memrq` outputs and the SDRAM CPU-ROM port.

## Interface
Parameters:
- `SDR_BASE`, default 25'h0000000: SDRAM byte address of CPU ROM offset 0.
- `SDR_AW`, default 25: SDRAM address width.

Ports:
- `clk_sys` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_req` in 1: CPU access strobe, level; held until `mem_ready` has been seen.
- `cpu_rom_memrq` in 1: decoder ROM select, qualifies `mem_req`.
- `rom_addr` in 20: decoded ROM byte address, already banked.
- `flush` in 1: invalidate the line buffer; pulse during ROM download or reset.
- `mem_dout` out 16: read data word.
- `mem_ready` out 1: one-cycle pulse; `mem_dout` is valid in the same cycle.
- `sdr_req` out 1: SDRAM request, level; held until `sdr_ack`.
- `sdr_addr` out SDR_AW: 8-byte-aligned SDRAM address.
- `sdr_ack` in 1: one-cycle pulse; `sdr_data` is valid in the same cycle.
- `sdr_data` in 64: line data; word 0 is in bits [15:0].

## Operation
- Line buffer: 64-bit `line`, tag `rom_addr[19:3]` (17 bits), `valid` bit.
- Word select: `rom_addr[2:1]`. `rom_addr[0]` is ignored; the CPU selects the byte itself.
- Start condition: `mem_req & cpu_rom_memrq` in IDLE.
- States:
  - IDLE, start with hit (`valid` and tag match): latch the word, pulse `mem_ready`, go to DONE.
  - IDLE, start with miss: latch the address, set `sdr_req`, drive `sdr_addr = SDR_BASE + {rom_addr[19:3],3'b000}`, go to FETCH.
  - FETCH, on `sdr_ack`: store `line` and the tag, clear `sdr_req`, output the selected word from `sdr_data`, pulse `mem_ready`, go to DONE.
  - DONE: wait for `mem_req` low, then go to IDLE. This gives exactly one response per CPU access.
- `rom_addr` is latched at start and ignored during FETCH and DONE.
- `mem_req` without `cpu_rom_memrq`: no action, stay in IDLE.
- `flush`:
  - Clears `valid` the same cycle, in any state.
  - If `flush` and `sdr_ack` land in the same cycle, the data is still returned to the CPU, but `valid` stays 0.
  - A fetch already in progress continues to completion.
- `sdr_ack` outside FETCH is ignored.
- Reset mid-FETCH drops `sdr_req` immediately. The SDRAM port tolerates an abandoned request.
- Reset values: `mem_dout` 0, `mem_ready` 0, `sdr_req` 0, `sdr_addr` 0, `valid` 0, state IDLE.

## Timing
- Hit: start sampled at edge N; `mem_ready` and `mem_dout` at N+1.
- Miss: `sdr_req` and `sdr_addr` are registered at N+1. With `sdr_ack` at edge M, `mem_ready` is at M+1 and `sdr_req` is low at M+1.
- A back-to-back access needs `mem_req` low for at least one cycle, so the minimum hit-to-hit period is 3 cycles.
- `sdr_addr` is stable for the whole time `sdr_req` is high.
- `mem_ready` is never high for two consecutive cycles.

## Structure
- `m92_pkg` additions:
  - `rom_line_t` (logic [63:0])
  - `rom_resp_state_t` enum: IDLE, FETCH, DONE
  - `ROM_TAG_W = 17`
- Single module, no sub-module. The line buffer is registers, not BRAM.

## Test plan
- Cold miss: reset, request `rom_addr` 20'h00006, `sdr_data` 64'h4444_3333_2222_1111, ack 5 cycles later. Required: `sdr_addr` 0x0000000, `mem_dout` 16'h4444 one cycle after ack, one `mem_ready` pulse.
- Hit: same line, request 20'h00002. Required: `mem_ready` at N+1 with 16'h2222, `sdr_req` stays 0.
- Miss to a new line with `SDR_BASE` 25'h0100000 and request 20'hA1238. Required: `sdr_addr` 25'h01A1238, old line replaced. A following request to 20'h00000 misses again.
- Flush racing ack: assert `flush` in the same cycle as `sdr_ack`. Required: data is returned, and the next request to the same address issues `sdr_req`.
- Non-ROM select: `mem_req` high with `cpu_rom_memrq` 0 for 10 cycles. Required: no `mem_ready`, no `sdr_req`. Also hold `mem_req` high through DONE for 10 cycles; required: only one `mem_ready` pulse.
- Reset mid-FETCH: drop `reset_n` while `sdr_req` is 1. Required: `sdr_req` goes to 0 asynchronously and `valid` is 0. A stray `sdr_ack` after reset produces no `mem_ready`.
